shifter_seq: RTL and testbench
==============================

Name: shifter_seq

Overview:
- Iterative multi-cycle shift/rotate unit. Sits directly downstream of the decode stage that emits shifter commands, and consumes shifter_types::cmd_t (NONE, SHL, SHR, ROL, ROR).
- Accepts one operation per valid/ready handshake and shifts one bit position per clock.
- Returns the result with carry and zero flags over a valid/ready output handshake to the register write-back path.

Parameters:
- WIDTH, 8, data path width in bits (≥2).
- AMT_W, $clog2(WIDTH), width of the shift-amount field; legal amounts 0..WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset; sampled on the rising clk edge.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- cmd  input  3  shifter_types::cmd_t command.
- data_in  input  WIDTH  operand.
- amount  input  AMT_W  number of bit positions.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- data_out  output  WIDTH  result.
- carry_out  output  1  last bit shifted or rotated out.
- zero  output  1  high when data_out == 0.

Behaviour:
- Reset (reset_n low at rising edge, in any state, including mid-shift):
  - state goes to IDLE; data_out, carry_out, count and the registered command clear to 0.
  - in_ready=1, out_valid=0, zero=1.
  - Any in-flight operation is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - Accept on an edge with in_valid & in_ready.
  - On accept, register data_in into data_out, cmd into cmd_r, amount into count; clear carry_out.
  - If cmd==NONE, amount==0, or cmd is an undefined encoding (5..7): go to DONE; data unchanged, carry_out=0.
  - Otherwise go to SHIFT.
- SHIFT: each edge performs one single-bit step on data_out and decrements count; goes to DONE on the edge where count reaches 0. in_ready=0.
  - SHL: data<<1, zero fill; carry_out = old MSB.
  - SHR: logical shift right, zero fill; carry_out = old LSB.
  - ROL: MSB wraps into LSB; carry_out = new LSB.
  - ROR: LSB wraps into MSB; carry_out = new MSB.
- Latency: counting the acceptance edge as edge 0, out_valid is high after edge N, where N=amount (N=0 for NONE/amount 0/undefined cmd). Maximum N is WIDTH-1.
- DONE:
  - out_valid=1; data_out, carry_out and zero are held stable while out_ready=0 (unbounded backpressure).
  - On an edge with out_ready=1, go to IDLE.
  - in_ready stays 0 in DONE, so there is no same-cycle accept. Back-to-back throughput is one operation per N+2 cycles.
- zero is combinational from data_out; it is valid whenever out_valid=1.
- in_valid or input changes while not in IDLE are ignored. Inputs are sampled only on the accept edge.

Optional Feature:
- SHIFTER_SEQ_BARREL_EN:
  - Defined: SHIFT is bypassed. On the accept edge, a combinational barrel shifter computes the full result and carry, with flag semantics identical to the iterative path, and the unit enters DONE directly. Latency N=0 for every command and amount.
  - Undefined: iterative one-bit-per-cycle behaviour as specified above.
  - The port list is identical either way.

Test Plan (WIDTH=8):
- SHL data_in=0x81 amount=1 → out_valid after edge 1; data_out=0x02, carry_out=1, zero=0.
- SHR 0x80 amount=7 → out_valid after edge 7; data_out=0x01, carry_out=0. in_ready stays 0 for edges 1..7; extra in_valid pulses during SHIFT are ignored.
- ROL 0xF0 amount=4 → 0x0F, carry_out=1. ROR 0x01 amount=3 → 0x20, carry_out=0. Both results match within N=amount.
- NONE 0x00 amount=5, and SHL 0x3C amount=0 → both reach DONE after edge 0:
  - NONE: data_out=0x00, zero=1, carry_out=0.
  - SHL: data_out=0x3C, carry_out=0.
- Backpressure: ROR 0xA5 amount=2 with out_ready=0 for 5 cycles → data_out=0x69, carry_out=0, all outputs stable, out_valid held. out_ready=1 → IDLE next edge, in_ready=1.
- Reset mid-operation: SHL 0xFF amount=6; reset_n low at edge 3 → IDLE, data_out=0, out_valid never asserted. Next request SHR 0x04 amount=2 → 0x01, carry_out=0.
- With SHIFTER_SEQ_BARREL_EN: repeat all cases above → identical results, out_valid after edge 0.

Source files
------------

// File: rtl/shifter_seq.sv
// Iterative shift/rotate unit: accepts one command per handshake, shifts one
// bit per clock, returns result with carry and zero flags.
// Optional build macro SHIFTER_SEQ_BARREL_EN replaces the iterative walk with a
// single-cycle barrel shifter; ports and flag semantics are unchanged.

package shifter_types;
  typedef enum logic [2:0] {
    NONE = 3'd0,
    SHL  = 3'd1,
    SHR  = 3'd2,
    ROL  = 3'd3,
    ROR  = 3'd4
  } cmd_t;
endpackage

module shifter_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       cmd,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AMT_W-1:0] amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             zero
);
  import shifter_types::*;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             carry_q, carry_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [2:0]       cmd_q, cmd_d;
  logic             shiftable;

  // One single-bit step; returns {carry, data}. Unknown commands pass the
  // data through with carry cleared.
  function automatic logic [WIDTH:0] step1(input logic [2:0] c,
                                           input logic [WIDTH-1:0] d);
    logic [WIDTH:0] r;
    r = {1'b0, d};
    case (c)
      SHL:     r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
      SHR:     r = {d[0], 1'b0, d[WIDTH-1:1]};
      ROL:     r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
      ROR:     r = {d[0], d[0], d[WIDTH-1:1]};
      default: r = {1'b0, d};
    endcase
    return r;
  endfunction

`ifdef SHIFTER_SEQ_BARREL_EN
  // Unrolled chain of single-bit steps; carry ends up as that of the last
  // applied step, so flags match the iterative path exactly.
  function automatic logic [WIDTH:0] barrel(input logic [2:0] c,
                                            input logic [WIDTH-1:0] d,
                                            input logic [AMT_W-1:0] a);
    logic [WIDTH:0] r;
    r = {1'b0, d};
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (i < int'(a)) r = step1(c, r[WIDTH-1:0]);
    end
    return r;
  endfunction
`endif

  assign shiftable = ((cmd == SHL) || (cmd == SHR) || (cmd == ROL) || (cmd == ROR))
                     && (amount != '0);

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign data_out  = data_q;
  assign carry_out = carry_q;
  assign zero      = (data_q == '0);

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    carry_d = carry_q;
    count_d = count_q;
    cmd_d   = cmd_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          data_d  = data_in;
          cmd_d   = cmd;
          count_d = amount;
          carry_d = 1'b0;
`ifdef SHIFTER_SEQ_BARREL_EN
          if (shiftable) {carry_d, data_d} = barrel(cmd, data_in, amount);
          state_d = S_DONE;
`else
          state_d = shiftable ? S_SHIFT : S_DONE;
`endif
        end
      end
      S_SHIFT: begin
        {carry_d, data_d} = step1(cmd_q, data_q);
        count_d = count_q - 1'b1;
        if (count_q == AMT_W'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      carry_q <= carry_d;
      count_q <= count_d;
      cmd_q   <= cmd_d;
    end
  end

endmodule

// File: tb/tb_shifter_seq.sv
// Self-checking bench for shifter_seq (WIDTH=8): directed vector table,
// reset/backpressure sequences, and random operations against an
// arithmetic reference model.

module tb_shifter_seq;
  localparam int W = 8;
  localparam int AW = 3;
`ifdef SHIFTER_SEQ_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    cmd;
  logic [W-1:0]  data_in;
  logic [AW-1:0] amount;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  data_out;
  logic          carry_out;
  logic          zero;

  int checks = 0;
  int failures = 0;

  shifter_seq #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .cmd(cmd), .data_in(data_in), .amount(amount), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .carry_out(carry_out),
    .zero(zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   c;
    logic [W-1:0] d;
    logic [AW-1:0] a;
    logic [W-1:0] ed;
    logic         ec;
    int           lat;
    int           hold;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: result computed directly from shift/rotate arithmetic.
  function automatic void model(input int c, input int d, input int n,
                                output int r, output int cy, output int lat);
    r = d; cy = 0; lat = 0;
    if (n != 0) begin
      case (c)
        1: begin r = (d << n) & 255; cy = (d >> (W - n)) & 1; lat = n; end
        2: begin r = d >> n; cy = (d >> (n - 1)) & 1; lat = n; end
        3: begin r = ((d << n) | (d >> (W - n))) & 255; cy = r & 1; lat = n; end
        4: begin r = ((d >> n) | (d << (W - n))) & 255; cy = (r >> (W - 1)) & 1; lat = n; end
        default: ;
      endcase
    end
    if (BARREL) lat = 0;
  endfunction

  // Issue one operation and check latency, result, flags, busy and release.
  task automatic run_op(input string name, input logic [2:0] c, input logic [W-1:0] d,
                        input logic [AW-1:0] a, input logic [W-1:0] ed, input logic ec,
                        input int elat, input int hold);
    int n;
    int lat;
    logic [W-1:0] held_d;
    logic held_c;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({name, "_ready_wait"}, in_ready, 1'b1);
    cmd = c; data_in = d; amount = a; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      chk({name, "_busy_in_ready"}, in_ready, 1'b0);
      in_valid = 1'b1;
      cmd = 3'($urandom_range(0, 7));
      data_in = W'($urandom);
      amount = AW'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    chk({name, "_latency"}, lat, elat);
    chk({name, "_data"}, data_out, ed);
    chk({name, "_carry"}, carry_out, ec);
    chk({name, "_zero"}, zero, (ed == 0));
    held_d = data_out;
    held_c = carry_out;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk({name, "_hold_valid"}, out_valid, 1'b1);
      chk({name, "_hold_data"}, data_out, held_d);
      chk({name, "_hold_carry"}, carry_out, held_c);
      chk({name, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({name, "_release_in_ready"}, in_ready, 1'b1);
    chk({name, "_release_out_valid"}, out_valid, 1'b0);
  endtask

  vec_t vecs[8];

  initial begin
    int r, cy, lat, rc, rd, ra, hd;
    vecs[0] = '{3'd1, 8'h81, 3'd1, 8'h02, 1'b1, 1, 0};
    vecs[1] = '{3'd2, 8'h80, 3'd7, 8'h01, 1'b0, 7, 0};
    vecs[2] = '{3'd3, 8'hF0, 3'd4, 8'h0F, 1'b1, 4, 0};
    vecs[3] = '{3'd4, 8'h01, 3'd3, 8'h20, 1'b0, 3, 0};
    vecs[4] = '{3'd0, 8'h00, 3'd5, 8'h00, 1'b0, 0, 0};
    vecs[5] = '{3'd1, 8'h3C, 3'd0, 8'h3C, 1'b0, 0, 0};
    vecs[6] = '{3'd4, 8'hA5, 3'd2, 8'h69, 1'b0, 2, 5};
    vecs[7] = '{3'd7, 8'h5A, 3'd3, 8'h5A, 1'b0, 0, 0};

    reset_n = 1'b0; in_valid = 1'b0; cmd = '0; data_in = '0; amount = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_carry", carry_out, 1'b0);
    chk("rst_zero", zero, 1'b1);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].c, vecs[i].d, vecs[i].a,
             vecs[i].ed, vecs[i].ec, BARREL ? 0 : vecs[i].lat, vecs[i].hold);
    end

    // Reset in the middle of an SHL 0xFF by 6.
    cmd = 3'd1; data_in = 8'hFF; amount = 3'd6; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!BARREL) chk("midrst_valid_e0", out_valid, 1'b0);
    @(posedge clk); #1;
    if (!BARREL) chk("midrst_valid_e1", out_valid, 1'b0);
    @(posedge clk); #1;
    if (!BARREL) chk("midrst_valid_e2", out_valid, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_data", data_out, 8'h00);
    chk("midrst_zero", zero, 1'b1);
    chk("midrst_carry", carry_out, 1'b0);
    run_op("post_rst", 3'd2, 8'h04, 3'd2, 8'h01, 1'b0, BARREL ? 0 : 2, 0);

    // Random operations against the arithmetic model.
    for (int k = 0; k < 40; k++) begin
      rc = $urandom_range(0, 7);
      rd = $urandom_range(0, 255);
      ra = $urandom_range(0, 7);
      hd = $urandom_range(0, 2);
      model(rc, rd, ra, r, cy, lat);
      run_op($sformatf("rnd%0d", k), 3'(rc), 8'(rd), 3'(ra), 8'(r), cy[0], lat, hd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
